hms_timekeeper: RTL and testbench
=================================

// Module: hms_timekeeper
// PURPOSE
//  Consumer end of the divided-clock path: samples the slow square wave from clock_divider
//  (clk_out) in the clk_in domain, converts each edge into a one-cycle tick, and keeps
//  24-hour BCD time (HH:MM:SS). Feeds the display driver; supports runtime set and pause.
// PARAMETERS
//  EDGE_MODE   1   0 = tick on rising edge only; 1 = tick on both edges (1 Hz from a toggle-per-second divider)
//  SYNC_STAGES 2   synchronizer flops on slow_clk (legal values 2..3)
// PORTS
//  clk_in     in   1   main FPGA clock
//  rst        in   1   synchronous reset, active high
//  slow_clk   in   1   divided square wave (clock_divider clk_out); treated as data, never as a clock
//  run        in   1   1 = count, 0 = hold time
//  set_valid  in   1   request to load set_time
//  set_time   in   24  BCD {h10[3:0],h1,m10,m1,s10,s1}
//  set_ready  out  1   set accepted this cycle when set_valid && set_ready
//  set_err    out  1   one-cycle pulse: accepted set_time was out of range; time unchanged
//  time_bcd   out  24  current time, same packing as set_time
//  sec_pulse  out  1   one-cycle pulse per applied tick
//  day_pulse  out  1   one-cycle pulse on 23:59:59 -> 00:00:00
//  alarm_set  in   1   load alarm_time from set_time (CLOCK_ALARM_EN only)
//  alarm_hit  out  1   one-cycle pulse on alarm match (CLOCK_ALARM_EN only)
// BEHAVIOUR
//  - Reset: time_bcd=00:00:00, all pulses 0, set_ready=1, sync/edge flops cleared to 0.
//    Reset mid-count discards any pending tick.
//  - Edge detect: SYNC_STAGES flops, then prev flop. tick = sync^prev (EDGE_MODE=1) or sync&~prev (0).
//  - Latency: slow_clk edge -> time_bcd/sec_pulse update SYNC_STAGES+1 clk_in cycles later.
//  - States: RUN (run=1) applies ticks; HOLD (run=0) ignores them.
//    The edge detector keeps tracking in HOLD, so resuming produces no burst.
//  - Increment per tick: s1 0..9, carry -> s10 0..5, carry -> m1 0..9, carry -> m10 0..5, carry -> hours.
//    h1 wraps at 9 when h10<2, at 3 when h10=2. 23:59:59 -> 00:00:00 with day_pulse.
//  - Set: set_ready is tied 1 (single-cycle accept). Valid iff each digit <=9, s10,m10 <=5, HH<=23.
//    Valid: time_bcd=set_time next cycle, no sec_pulse. Invalid: set_err=1 one cycle, time held.
//  - Set and tick in the same cycle: set wins; the tick is dropped (no sec_pulse).
//  - Set is honoured in HOLD.
//  - Digit fields never hold non-BCD values. h10 is stored 2 bits, zero-extended to 4 in time_bcd.
// CONFIGURATION
//  - CLOCK_ALARM_EN defined: 24-bit alarm register (reset 00:00:00, valid flag 0).
//    alarm_set loads it under the same range check (invalid -> set_err) and sets the valid flag.
//    alarm_hit pulses the cycle after a tick or set makes time_bcd == alarm while valid.
//    If alarm_set and set_valid are both high, both are taken from set_time.
//  - CLOCK_ALARM_EN undefined: alarm_set ignored, alarm_hit tied 0, no alarm register.
//    Ports remain so the top level is unchanged.
// STRUCTURE
//  - Package clock_pkg: digit limits (SEC_TENS_MAX=5, MIN_TENS_MAX=5, HOUR_MAX=23)
//    and the time_bcd field offsets.
//  - Package clock_pkg: typedef hms_t (packed BCD struct) and function bcd_time_valid().
//  - Sub-module bcd_digit_counter #(MAX): inc, load, load_val -> digit, carry_out.
//    Six instances, with an hour-pair override for the 23 wrap.
//  - Synchronizer and edge detect stay inline (no CDC library dependency).
// TESTING
//  1 Reset, then slow_clk toggles 3 times (EDGE_MODE=1).
//    -> time_bcd 00:00:03, 3 sec_pulses, each SYNC_STAGES+1 cycles after its edge.
//  2 set_time 23:59:58, then 2 edges.
//    -> 23:59:59, then 00:00:00 with day_pulse=1 on exactly that cycle.
//  3 set_time 12:60:00 and 24:00:00.
//    -> set_err pulse each time, time_bcd unchanged.
//  4 set_valid (10:00:00) in the same cycle a tick is applied.
//    -> 10:00:00, no sec_pulse. run=0 then 5 edges -> time frozen. run=1 -> next edge +1 s only.
//  5 Assert rst one cycle after a slow_clk edge.
//    -> time 00:00:00, no sec_pulse afterwards for that edge.
//  6 CLOCK_ALARM_EN: alarm 00:00:05, 5 edges -> single alarm_hit pulse.
//    Without the macro, alarm_hit stays 0 throughout.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared BCD time-of-day type, digit limits, field offsets and the range check
// used for set and alarm loads.
package clock_pkg;

  localparam logic [3:0] DIGIT_MAX    = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] MIN_TENS_MAX = 4'd5;
  localparam logic [7:0] HOUR_MAX     = 8'h23;  // BCD-encoded hour pair

  // Nibble offsets of each digit inside time_bcd / set_time.
  localparam int unsigned S1_LSB  = 0;
  localparam int unsigned S10_LSB = 4;
  localparam int unsigned M1_LSB  = 8;
  localparam int unsigned M10_LSB = 12;
  localparam int unsigned H1_LSB  = 16;
  localparam int unsigned H10_LSB = 20;

  typedef struct packed {
    logic [3:0] h10;
    logic [3:0] h1;
    logic [3:0] m10;
    logic [3:0] m1;
    logic [3:0] s10;
    logic [3:0] s1;
  } hms_t;

  // Hour pair compared as BCD; only meaningful once h1 is known to be a digit.
  function automatic logic bcd_time_valid(input hms_t t);
    return (t.s1 <= DIGIT_MAX) && (t.s10 <= SEC_TENS_MAX) &&
           (t.m1 <= DIGIT_MAX) && (t.m10 <= MIN_TENS_MAX) &&
           (t.h1 <= DIGIT_MAX) && ({t.h10, t.h1} <= HOUR_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit of the time-of-day chain: loadable, increments on inc_i and
// wraps at MAX (or early when wrap_i is asserted), producing a carry on wrap.
module bcd_digit_counter #(
  parameter int unsigned WIDTH = 4,
  parameter logic [3:0]  MAX   = 4'd9
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             wrap_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] digit_o,
  output logic             carry_out_o
);

  logic [WIDTH-1:0] digit_q, digit_d;
  logic             at_max;

  assign at_max      = (digit_q == MAX[WIDTH-1:0]) || wrap_i;
  assign carry_out_o = inc_i && !load_i && at_max;
  assign digit_o     = digit_q;

  // Load has priority over increment.
  always_comb begin
    digit_d = digit_q;
    if (load_i) begin
      digit_d = load_val_i;
    end else if (inc_i) begin
      digit_d = at_max ? '0 : digit_q + 1'b1;
    end
  end

  // Digit register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

endmodule

// File: rtl/hms_timekeeper.sv
// 24-hour BCD timekeeper driven by a divided square wave sampled as data.
// Optional alarm comparator is enabled by defining CLOCK_ALARM_EN.
module hms_timekeeper
  import clock_pkg::*;
#(
  parameter int unsigned EDGE_MODE   = 1,  // 0: rising edges tick, 1: both edges tick
  parameter int unsigned SYNC_STAGES = 2   // 2..3
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        slow_clk,
  input  logic        run,
  input  logic        set_valid,
  input  logic [23:0] set_time,
  output logic        set_ready,
  output logic        set_err,
  output logic [23:0] time_bcd,
  output logic        sec_pulse,
  output logic        day_pulse,
  input  logic        alarm_set,
  output logic        alarm_hit
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   sync_out, tick, apply_tick;
  hms_t                   set_t;
  logic                   set_ok, set_req, load_time;
  logic                   sec_pulse_q, day_pulse_q, set_err_q;

  logic [3:0] s1, s10, m1, m10, h1;
  logic [1:0] h10;
  logic       c_s1, c_s10, c_m1, c_m10, c_h1, c_h10;
  logic       hour_wrap;

  // slow_clk is only ever sampled; synchronizer chain followed by the edge-history flop.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], slow_clk};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign tick     = (EDGE_MODE != 0) ? (sync_out ^ prev_q) : (sync_out & ~prev_q);

  assign set_t     = hms_t'(set_time);
  assign set_ok    = bcd_time_valid(set_t);
  assign load_time = set_valid & set_ok;
  // A set request in the same cycle swallows the tick; run=0 holds time while
  // the edge detector keeps tracking so resuming does not replay old edges.
  assign apply_tick = tick & run & ~set_valid;
  assign set_ready  = 1'b1;

  // 23 -> 00: force the units-of-hours digit to wrap at 3 when tens is 2.
  assign hour_wrap = (h10 == HOUR_MAX[5:4]) && (h1 == HOUR_MAX[3:0]);

  bcd_digit_counter #(.WIDTH(4), .MAX(DIGIT_MAX)) u_s1 (
    .clk_i(clk_in), .rst_i(rst), .inc_i(apply_tick), .wrap_i(1'b0),
    .load_i(load_time), .load_val_i(set_t.s1), .digit_o(s1), .carry_out_o(c_s1)
  );
  bcd_digit_counter #(.WIDTH(4), .MAX(SEC_TENS_MAX)) u_s10 (
    .clk_i(clk_in), .rst_i(rst), .inc_i(c_s1), .wrap_i(1'b0),
    .load_i(load_time), .load_val_i(set_t.s10), .digit_o(s10), .carry_out_o(c_s10)
  );
  bcd_digit_counter #(.WIDTH(4), .MAX(DIGIT_MAX)) u_m1 (
    .clk_i(clk_in), .rst_i(rst), .inc_i(c_s10), .wrap_i(1'b0),
    .load_i(load_time), .load_val_i(set_t.m1), .digit_o(m1), .carry_out_o(c_m1)
  );
  bcd_digit_counter #(.WIDTH(4), .MAX(MIN_TENS_MAX)) u_m10 (
    .clk_i(clk_in), .rst_i(rst), .inc_i(c_m1), .wrap_i(1'b0),
    .load_i(load_time), .load_val_i(set_t.m10), .digit_o(m10), .carry_out_o(c_m10)
  );
  bcd_digit_counter #(.WIDTH(4), .MAX(DIGIT_MAX)) u_h1 (
    .clk_i(clk_in), .rst_i(rst), .inc_i(c_m10), .wrap_i(hour_wrap),
    .load_i(load_time), .load_val_i(set_t.h1), .digit_o(h1), .carry_out_o(c_h1)
  );
  bcd_digit_counter #(.WIDTH(2), .MAX(HOUR_MAX[7:4])) u_h10 (
    .clk_i(clk_in), .rst_i(rst), .inc_i(c_h1), .wrap_i(1'b0),
    .load_i(load_time), .load_val_i(set_t.h10[1:0]), .digit_o(h10), .carry_out_o(c_h10)
  );

  // Pack the digits back into the external layout; h10 is zero-extended.
  always_comb begin
    time_bcd = '0;
    time_bcd[H10_LSB +: 4] = {2'b00, h10};
    time_bcd[H1_LSB +: 4]  = h1;
    time_bcd[M10_LSB +: 4] = m10;
    time_bcd[M1_LSB +: 4]  = m1;
    time_bcd[S10_LSB +: 4] = s10;
    time_bcd[S1_LSB +: 4]  = s1;
  end

  // Status pulses line up with the cycle the new time becomes visible.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      sec_pulse_q <= 1'b0;
      day_pulse_q <= 1'b0;
      set_err_q   <= 1'b0;
    end else begin
      sec_pulse_q <= apply_tick;
      day_pulse_q <= c_h10;
      set_err_q   <= set_req & ~set_ok;
    end
  end

  assign sec_pulse = sec_pulse_q;
  assign day_pulse = day_pulse_q;
  assign set_err   = set_err_q;

`ifdef CLOCK_ALARM_EN
  hms_t alarm_q;
  logic alarm_vld_q, check_q, alarm_hit_q;

  assign set_req = set_valid | alarm_set;

  // Alarm register; compare one cycle after time_bcd changes by tick or set.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      alarm_q     <= '0;
      alarm_vld_q <= 1'b0;
      check_q     <= 1'b0;
      alarm_hit_q <= 1'b0;
    end else begin
      if (alarm_set && set_ok) begin
        alarm_q     <= set_t;
        alarm_vld_q <= 1'b1;
      end
      check_q     <= apply_tick | load_time;
      alarm_hit_q <= check_q & alarm_vld_q & (time_bcd == alarm_q);
    end
  end

  assign alarm_hit = alarm_hit_q;
`else
  logic unused_alarm_set;
  assign unused_alarm_set = alarm_set;
  assign set_req          = set_valid;
  assign alarm_hit        = 1'b0;
`endif

endmodule

// File: tb/tb_hms_timekeeper.sv
// Directed bench for hms_timekeeper: a scoreboard queue holds the expected
// time and arrival cycle of every sec_pulse; a negedge monitor pops and checks.
module tb_hms_timekeeper;

  localparam int unsigned SYNC = 2;
  localparam int LAT = SYNC + 1;

  logic        clk_in = 1'b0;
  logic        rst, slow_clk, run, set_valid, alarm_set;
  logic [23:0] set_time;
  logic        set_ready, set_err, sec_pulse, day_pulse, alarm_hit;
  logic [23:0] time_bcd;

  typedef struct {
    logic [23:0] t;
    int          cyc;
    logic        day;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   secs = 0;
  int   alarm_hits = 0;
  int   exp_alarm_cyc = -1;

  hms_timekeeper #(.EDGE_MODE(1), .SYNC_STAGES(SYNC)) dut (
    .clk_in(clk_in), .rst(rst), .slow_clk(slow_clk), .run(run),
    .set_valid(set_valid), .set_time(set_time), .set_ready(set_ready),
    .set_err(set_err), .time_bcd(time_bcd), .sec_pulse(sec_pulse),
    .day_pulse(day_pulse), .alarm_set(alarm_set), .alarm_hit(alarm_hit)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  function automatic logic [23:0] to_bcd(input int s);
    int h, m, x;
    h = s / 3600;
    m = (s / 60) % 60;
    x = s % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  // Edge that must be applied: model advances and the result is queued.
  task automatic edge_tick();
    exp_t e;
    slow_clk = ~slow_clk;
    secs     = (secs + 1) % 86400;
    e.t      = to_bcd(secs);
    e.cyc    = cyc + LAT;
    e.day    = (secs == 0);
    sb.push_back(e);
  endtask

  task automatic edge_quiet();
    slow_clk = ~slow_clk;
  endtask

  task automatic do_set(input logic [23:0] v);
    set_time  = v;
    set_valid = 1'b1;
    step(1);
    set_valid = 1'b0;
  endtask

  // Every sec_pulse must match the head of the scoreboard in value and timing.
  always @(negedge clk_in) begin
    exp_t e;
    if (sec_pulse) begin
      if (sb.size() == 0) begin
        chk("sec_pulse_unexpected", {31'b0, sec_pulse}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("tick_time", {8'b0, time_bcd}, {8'b0, e.t});
        chk("tick_cycle", cyc, e.cyc);
        chk("tick_day_pulse", {31'b0, day_pulse}, {31'b0, e.day});
      end
    end else if (day_pulse) begin
      chk("day_pulse_stray", {31'b0, day_pulse}, 32'd0);
    end
    if (alarm_hit) begin
      alarm_hits++;
      chk("alarm_hit_cycle", cyc, exp_alarm_cyc);
    end
  end

  initial begin
    rst = 1'b1; slow_clk = 1'b0; run = 1'b1; set_valid = 1'b0;
    alarm_set = 1'b0; set_time = '0;

    // Reset state
    step(3);
    chk("rst_time", {8'b0, time_bcd}, 32'd0);
    chk("rst_set_ready", {31'b0, set_ready}, 32'd1);
    chk("rst_sec_pulse", {31'b0, sec_pulse}, 32'd0);
    rst = 1'b0;
    step(1);
    chk("post_rst_time", {8'b0, time_bcd}, 32'd0);
    chk("post_rst_set_err", {31'b0, set_err}, 32'd0);

    // 1: three edges, both polarities tick
    for (int i = 0; i < 3; i++) begin
      edge_tick();
      step(6);
    end
    chk("t1_time", {8'b0, time_bcd}, 32'h000003);

    // 2: day rollover
    do_set(24'h235958);
    secs = 23 * 3600 + 59 * 60 + 58;
    chk("t2_set_load", {8'b0, time_bcd}, 32'h235958);
    chk("t2_set_err", {31'b0, set_err}, 32'd0);
    edge_tick();
    step(6);
    chk("t2_time_a", {8'b0, time_bcd}, 32'h235959);
    edge_tick();
    step(6);
    chk("t2_time_b", {8'b0, time_bcd}, 32'h000000);

    // 3: out-of-range sets leave time alone
    do_set(24'h083015);
    secs = 8 * 3600 + 30 * 60 + 15;
    chk("t3_valid_set", {8'b0, time_bcd}, 32'h083015);
    do_set(24'h126000);
    chk("t3_err_min", {31'b0, set_err}, 32'd1);
    chk("t3_hold_min", {8'b0, time_bcd}, 32'h083015);
    step(1);
    chk("t3_err_one_cycle", {31'b0, set_err}, 32'd0);
    do_set(24'h240000);
    chk("t3_err_hour", {31'b0, set_err}, 32'd1);
    chk("t3_hold_hour", {8'b0, time_bcd}, 32'h083015);
    do_set(24'h00005A);
    chk("t3_err_digit", {31'b0, set_err}, 32'd1);
    chk("t3_hold_digit", {8'b0, time_bcd}, 32'h083015);
    step(1);

    // 4: set collides with the tick; then hold and resume
    edge_quiet();
    step(SYNC);
    set_time  = 24'h100000;
    set_valid = 1'b1;
    step(1);
    set_valid = 1'b0;
    secs = 10 * 3600;
    chk("t4_collide_time", {8'b0, time_bcd}, 32'h100000);
    chk("t4_collide_err", {31'b0, set_err}, 32'd0);
    step(6);
    run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      edge_quiet();
      step(6);
    end
    chk("t4_hold_time", {8'b0, time_bcd}, 32'h100000);
    run = 1'b1;
    edge_tick();
    step(6);
    chk("t4_resume_time", {8'b0, time_bcd}, 32'h100001);

    // 5: reset right after an edge; the pending tick must vanish
    if (slow_clk == 1'b0) begin
      edge_tick();
      step(6);
    end
    edge_quiet();
    step(1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    secs = 0;
    step(10);
    chk("t5_time", {8'b0, time_bcd}, 32'h000000);

    // 6: alarm at 00:00:05
    set_time  = 24'h000005;
    alarm_set = 1'b1;
    step(1);
    alarm_set = 1'b0;
    chk("t6_alarm_set_err", {31'b0, set_err}, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      edge_tick();
`ifdef CLOCK_ALARM_EN
      if (i == 5) exp_alarm_cyc = cyc + LAT + 1;
`endif
      step(6);
    end
    step(4);
    chk("t6_time", {8'b0, time_bcd}, 32'h000005);
`ifdef CLOCK_ALARM_EN
    chk("t6_alarm_hits", alarm_hits, 32'd1);
`else
    chk("t6_alarm_hits", alarm_hits, 32'd0);
`endif

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
